// File: rtl/poly_mau_pkg.sv
// Shared constants and types for the polynomial MAU and its sequencers.
//   Q, BARRET_M, MM_N : Dilithium modulus, Barrett constant and Montgomery width
//   ALU_PWM           : MAU ALU opcode for pointwise multiply
//   N_COEF_DEF        : default coefficients per polynomial
//   pwm_state_e       : PWM sequencer FSM states
package poly_mau_pkg;

    localparam logic [23:0] Q          = 24'd8380417;
    localparam logic [24:0] BARRET_M   = 25'd8396807;
    localparam logic [4:0]  MM_N       = 5'd23;
    localparam logic [3:0]  ALU_PWM    = 4'b0100;
    localparam int unsigned N_COEF_DEF = 256;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } pwm_state_e;

endpackage

// File: rtl/poly_pwm_vdelay.sv
// Valid-bit delay line: i_valid emerges on o_valid DEPTH cycles later.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (line clears to all-zero)
//   i_valid        : valid bit in
//   o_valid        : valid bit delayed by DEPTH cycles
module poly_pwm_vdelay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[DEPTH-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/poly_pwm_ctrl.sv
// Pointwise-multiply sequencer for the polynomial MAU (Dilithium).
// Streams N_COEF coefficient pairs from the A/B RAMs into the MAU at one per cycle and
// writes each in-order MAU result to the result RAM. Completion is counted, not timed.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start, i_hold       : begin a pass (ignored while busy); stall read issue
//   o_busy, o_done, o_err : pass active; 1-cycle completion pulse; sticky protocol error
//   o_rd_en, o_rd_addr    : shared A/B RAM read strobe and address
//   i_rd_a, i_rd_b        : A/B RAM read data
//   o_mau_a/b, o_mau_enable, i_mau_valid, i_mau_o0 : MAU data path
//   o_mau_kd_sel, o_mau_alu_mode, o_mau_q, o_mau_barret_m, o_mau_mm_N : MAU static config
//   o_wr_en, o_wr_addr, o_wr_data : result RAM write port
module poly_pwm_ctrl
    import poly_mau_pkg::*;
#(
    parameter int unsigned N_COEF = N_COEF_DEF,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [23:0]       i_rd_a,
    input  logic [23:0]       i_rd_b,
    output logic [23:0]       o_mau_a,
    output logic [23:0]       o_mau_b,
    output logic              o_mau_enable,
    input  logic              i_mau_valid,
    input  logic [23:0]       i_mau_o0,
    output logic              o_mau_kd_sel,
    output logic [3:0]        o_mau_alu_mode,
    output logic [23:0]       o_mau_q,
    output logic [24:0]       o_mau_barret_m,
    output logic [4:0]        o_mau_mm_N,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [23:0]       o_wr_data
);

    // One extra bit so the counters can hold N_COEF itself.
    localparam int unsigned     CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_COEF);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_COEF - 1);

    pwm_state_e        r_state;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              w_issue;
    logic              w_wr_en;
    logic              w_err_set;
    logic [CNT_W-1:0]  w_wr_cnt_nxt;

    assign w_issue      = (r_state == StRun) && !i_hold && (r_rd_cnt < N_CNT);
    assign w_wr_en      = i_mau_valid && ((r_state == StRun) || (r_state == StDrain))
                          && (r_wr_cnt < N_CNT);
    // Any MAU result that cannot be written is a protocol violation upstream.
    assign w_err_set    = i_mau_valid && !w_wr_en;
    assign w_wr_cnt_nxt = r_wr_cnt + CNT_W'(w_wr_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_wr_cnt <= w_wr_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_err    <= w_err_set;
                        r_busy   <= 1'b1;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    if (w_issue) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_cnt[ADDR_W-1:0];
                        r_rd_cnt  <= r_rd_cnt + 1'b1;
                        if (r_rd_cnt == N_LAST) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Look at the post-write count so done follows the last write directly.
                    if (w_wr_cnt_nxt >= N_CNT) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    poly_pwm_vdelay #(
        .DEPTH (RD_LAT)
    ) u_vdelay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (r_rd_en),
        .o_valid (o_mau_enable)
    );

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_rd_en        = r_rd_en;
    assign o_rd_addr      = r_rd_addr;
    assign o_mau_a        = i_rd_a;
    assign o_mau_b        = i_rd_b;
    assign o_wr_en        = w_wr_en;
    assign o_wr_addr      = r_wr_cnt[ADDR_W-1:0];
    assign o_wr_data      = i_mau_o0;
    assign o_mau_kd_sel   = 1'b1;
    assign o_mau_alu_mode = ALU_PWM;
    assign o_mau_q        = Q;
    assign o_mau_barret_m = BARRET_M;
    assign o_mau_mm_N     = MM_N;

endmodule

// File: tb/tb_poly_pwm_ctrl.sv
// Directed bench for poly_pwm_ctrl: A/B RAMs with 1-cycle read latency and a fixed-latency
// MAU stub (o0 = a ^ b) surround the sequencer; a monitor checks every read and write.
module tb_poly_pwm_ctrl;

    localparam int NC  = 256;
    localparam int LAT = 3;
    localparam int RDL = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic        force_valid;
    logic        busy, done, err, rd_en, mau_enable, wr_en, kd_sel;
    logic [7:0]  rd_addr, wr_addr;
    logic [23:0] rd_a, rd_b, mau_a, mau_b, mau_o0, wr_data, q;
    logic [24:0] barret_m;
    logic [4:0]  mm_n;
    logic [3:0]  alu_mode;
    logic        mau_valid;

    logic [23:0] mem_a [NC];
    logic [23:0] mem_b [NC];
    logic [LAT-1:0] vpipe;
    logic [23:0]    dpipe [LAT];

    int n_cmp;
    int n_bad;
    int wr_seen;
    int rd_seen;
    int done_seen;
    int lat;

    poly_pwm_ctrl u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_hold         (hold),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_rd_en        (rd_en),
        .o_rd_addr      (rd_addr),
        .i_rd_a         (rd_a),
        .i_rd_b         (rd_b),
        .o_mau_a        (mau_a),
        .o_mau_b        (mau_b),
        .o_mau_enable   (mau_enable),
        .i_mau_valid    (mau_valid),
        .i_mau_o0       (mau_o0),
        .o_mau_kd_sel   (kd_sel),
        .o_mau_alu_mode (alu_mode),
        .o_mau_q        (q),
        .o_mau_barret_m (barret_m),
        .o_mau_mm_N     (mm_n),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Coefficient RAMs, one cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= '0;
            rd_b <= '0;
        end else if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

    // MAU stub: fixed latency LAT, o0 = a ^ b.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[LAT-2:0], mau_enable};
            dpipe[0] <= mau_a ^ mau_b;
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    assign mau_valid = vpipe[LAT-1] | force_valid;
    assign mau_o0    = dpipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every read must walk 0..NC-1 and every write must land in order with a^b.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                check_eq("rd_in_range", 32'(rd_seen < NC), 1);
                check_eq("rd_addr", 32'(rd_addr), 32'(rd_seen));
                rd_seen++;
            end
            if (wr_en) begin
                check_eq("wr_in_range", 32'(wr_seen < NC), 1);
                if (wr_seen < NC) begin
                    check_eq("wr_addr", 32'(wr_addr), 32'(wr_seen));
                    check_eq("wr_data", 32'(wr_data), 32'(mem_a[wr_seen] ^ mem_b[wr_seen]));
                end
                wr_seen++;
            end
            if (done) done_seen++;
        end
    end

    // One pass: start pulse, then wait (bounded) for done; lat = cycles from start edge to done.
    task automatic run_pass(input bit hold_on, input bit restart, output int lat_o);
        int  k;
        bit  seen;
        wr_seen   = 0;
        rd_seen   = 0;
        done_seen = 0;
        lat_o     = -1;
        seen      = 1'b0;
        k         = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && k < 2000) begin
            @(negedge clk);
            if (k == 0) check_eq("err_cleared", 32'(err), 0);
            hold  = hold_on && (k % 3 == 2);
            start = restart && ((k == 10) || done);
            if (done) begin
                seen  = 1'b1;
                lat_o = k;
            end else if (hold_on) begin
                check_eq("busy_in_pass", 32'(busy), 1);
            end
            k++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hold  = 1'b0;
        if (!seen) check_eq("done_timeout", 0, 1);
        repeat (20) @(negedge clk);
        check_eq("wr_total", 32'(wr_seen), NC);
        check_eq("rd_total", 32'(rd_seen), NC);
        check_eq("done_pulses", 32'(done_seen), 1);
        check_eq("busy_after", 32'(busy), 0);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        wr_seen     = 0;
        rd_seen     = 0;
        done_seen   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        hold        = 1'b0;
        force_valid = 1'b0;
        for (int i = 0; i < NC; i++) begin
            mem_a[i] = 24'(i);
            mem_b[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_rd_en", 32'(rd_en), 0);
        check_eq("rst_mau_en", 32'(mau_enable), 0);
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_rd_addr", 32'(rd_addr), 0);
        check_eq("rst_wr_addr", 32'(wr_addr), 0);

        // Static MAU configuration
        check_eq("cfg_q", 32'(q), 8380417);
        check_eq("cfg_barret_m", 32'(barret_m), 8396807);
        check_eq("cfg_mm_n", 32'(mm_n), 23);
        check_eq("cfg_alu_mode", 32'(alu_mode), 4);
        check_eq("cfg_kd_sel", 32'(kd_sel), 1);

        // 1: plain pass, done latency 256 + RD_LAT + L + 1
        run_pass(1'b0, 1'b0, lat);
        check_eq("done_latency", 32'(lat), NC + RDL + LAT + 1);

        // 2: hold every 3rd cycle, nonzero B
        for (int i = 0; i < NC; i++) mem_b[i] = 24'((i * 37) ^ 24'h5a5a00);
        run_pass(1'b1, 1'b0, lat);
        check_eq("hold_slower", 32'(lat > NC + RDL + LAT + 1), 1);

        // 3: start while busy and during done is ignored
        run_pass(1'b0, 1'b1, lat);
        check_eq("restart_latency", 32'(lat), NC + RDL + LAT + 1);

        // 4: stray MAU valid while idle
        @(negedge clk);
        force_valid = 1'b1;
        #1 check_eq("idle_valid_wr_en", 32'(wr_en), 0);
        @(posedge clk);
        #1 force_valid = 1'b0;
        check_eq("idle_valid_err", 32'(err), 1);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", 32'(err), 1);
        run_pass(1'b0, 1'b0, lat);

        // 5: reset mid-pass
        wr_seen = 0;
        rd_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_busy", 32'(busy), 0);
        check_eq("rstmid_rd_en", 32'(rd_en), 0);
        check_eq("rstmid_wr_en", 32'(wr_en), 0);
        check_eq("rstmid_done", 32'(done), 0);
        check_eq("rstmid_mau_en", 32'(mau_enable), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(1'b0, 1'b0, lat);
        check_eq("post_rst_latency", 32'(lat), NC + RDL + LAT + 1);
        check_eq("post_rst_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
